// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber NTT datapath.
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int KYBER_W   = 12;
    localparam int BARRETT_K = 24;
    localparam int BARRETT_M = 5039;

    typedef logic [11:0] coeff_t;

endpackage

// File: rtl/kyber_mult_if.sv
// Operand/result bundle for the pipelined modular multiplier.
interface kyber_mult_if
    import kyber_pkg::*;
#(
    parameter int W = KYBER_W
);

    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] res;

    modport master (output in1, output in2, input res);
    modport slave  (input in1, input in2, output res);

endinterface

// File: rtl/kyber_barrett_reduce.sv
// Two-stage Barrett reduction of a 2W-bit product into a canonical residue mod Q.
module kyber_barrett_reduce
    import kyber_pkg::*;
#(
    parameter int W = KYBER_W,
    parameter int Q = KYBER_Q
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*W-1:0] p,
    output logic [W-1:0]   res
);

    localparam int    PW = 2 * W;
    localparam int    RW = W + 2;
    localparam int    K  = 2 * W;
    localparam int    MW = 2 * PW + 1;
    localparam longint M = (longint'(1) << K) / longint'(Q);

    logic [MW-1:0] prod_m;
    logic [PW-1:0] qh;
    logic [RW-1:0] r0_d;
    logic [RW-1:0] r0;
    logic [W-1:0]  res_d;

    // Quotient estimate undershoots by at most 2, so p - qh*Q stays below 3Q.
    always_comb begin
        prod_m = MW'(p) * MW'(M);
        qh     = PW'(prod_m >> K);
        r0_d   = RW'(p - PW'(qh * PW'(Q)));
    end

    // Stage 2 register: partially reduced residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r0 <= '0;
        else     r0 <= r0_d;
    end

    // Final correction brings the residue from 0..3Q-1 into 0..Q-1.
    always_comb begin
        res_d = W'(r0);
        if (r0 >= RW'(2 * Q))  res_d = W'(r0 - RW'(2 * Q));
        else if (r0 >= RW'(Q)) res_d = W'(r0 - RW'(Q));
    end

    // Stage 3 register: canonical result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) res <= '0;
        else     res <= res_d;
    end

endmodule

// File: rtl/kyber_mult.sv
// Pipelined (in1*in2) mod Q multiplier: product register followed by Barrett reduction.
module kyber_mult
    import kyber_pkg::*;
#(
    parameter int W = KYBER_W,
    parameter int Q = KYBER_Q
) (
    input logic        clk,
    input logic        rst,
    kyber_mult_if.slave bus
);

    localparam int PW = 2 * W;

    logic [PW-1:0] p;

    // Stage 1 register: full-width unsigned product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p <= '0;
        else     p <= PW'(bus.in1) * PW'(bus.in2);
    end

    kyber_barrett_reduce #(
        .W (W),
        .Q (Q)
    ) u_reduce (
        .clk (clk),
        .rst (rst),
        .p   (p),
        .res (bus.res)
    );

endmodule

// File: tb/tb_kyber_mult.sv
// Self-checking bench for kyber_mult: directed corner cases plus random stream vs. (a*b)%Q.
module tb_kyber_mult;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    kyber_mult_if #(.W(KYBER_W)) kif ();

    kyber_mult #(
        .W (KYBER_W),
        .Q (KYBER_Q)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif.slave)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    // Reference delay line: slot 0 holds the newest expected residue, slot 2 what res must show.
    int expLine [3];

    function automatic int refMod(input int a, input int b);
        return (a * b) % KYBER_Q;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    endtask

    task automatic applyStimulus(input int a, input int b);
        kif.in1 = coeff_t'(a);
        kif.in2 = coeff_t'(b);
    endtask

    // One clock: update the reference at the edge, then check at the following falling edge.
    task automatic stepCycle(input string tag);
        @(posedge clk);
        if (rst) begin
            expLine = '{0, 0, 0};
        end else begin
            expLine[2] = expLine[1];
            expLine[1] = expLine[0];
            expLine[0] = refMod(int'(kif.in1), int'(kif.in2));
        end
        @(negedge clk);
        checkOutput(tag, int'(kif.res), expLine[2]);
        checkOutput({tag, "_range"}, int'(kif.res < coeff_t'(KYBER_Q)), 1);
    endtask

    task automatic holdAndCheck(input string tag, input int a, input int b,
                                input int cycles, input int expected);
        applyStimulus(a, b);
        for (int i = 0; i < cycles; i++) stepCycle(tag);
        checkOutput({tag, "_const"}, int'(kif.res), expected);
    endtask

    int bndA [5] = '{0, 3328, 3329, 4095, 1};
    int bndB [5] = '{4095, 3328, 1, 4095, 3328};
    int bndR [5] = '{0, 1, 0, 852, 3328};

    initial begin
        expLine = '{0, 0, 0};
        applyStimulus(1234, 2345);

        // Asynchronous reset, checked before any clock edge has occurred.
        #2 rst = 1'b1;
        #1 checkOutput("reset_async", int'(kif.res), 0);
        stepCycle("reset_hold");
        stepCycle("reset_hold");

        // Release and first result three edges later.
        rst = 1'b0;
        holdAndCheck("basic", 10, 300, 3, 3000);

        // Large in-range operands.
        holdAndCheck("large_a", 3300, 3290, 5, 1131);
        holdAndCheck("large_b", 3000, 3111, 3, 1813);
        holdAndCheck("small",   200,  10,   3, 2000);

        // Boundary operands, each held until its result emerges.
        for (int i = 0; i < 5; i++)
            holdAndCheck($sformatf("bnd%0d", i), bndA[i], bndB[i], 3, bndR[i]);

        // Same boundary operands back-to-back, one pair per cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(bndA[i], bndB[i]);
            stepCycle("b2b");
        end
        applyStimulus(7, 9);
        for (int i = 0; i < 3; i++) stepCycle("b2b_drain");

        // Reset with three distinct products in flight.
        applyStimulus(111, 222); stepCycle("fill");
        applyStimulus(333, 444); stepCycle("fill");
        applyStimulus(555, 666); stepCycle("fill");
        #1 rst = 1'b1;
        #1 begin
            checkOutput("reset_mid", int'(kif.res), 0);
            expLine = '{0, 0, 0};
        end
        stepCycle("reset_mid_hold");
        stepCycle("reset_mid_hold");
        rst = 1'b0;
        applyStimulus(2000, 3000);
        stepCycle("refill");
        checkOutput("refill_e1", int'(kif.res), 0);
        stepCycle("refill");
        checkOutput("refill_e2", int'(kif.res), 0);
        stepCycle("refill");
        checkOutput("refill_e3", int'(kif.res), (2000 * 3000) % KYBER_Q);

        // Random stream, new pair each cycle.
        for (int i = 0; i < 20000; i++) begin
            applyStimulus(int'($urandom_range(4095, 0)), int'($urandom_range(4095, 0)));
            stepCycle("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
